demux_router_reg: RTL and testbench

//  Parametrised, registered 1-to-N_OUT demultiplexer with valid/ready handshake.

---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_slot.sv | 50 +++++
 rtl/demux_router_reg.sv | 90 +++++++++
 tb/tb_demux_router_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared helpers for the registered 1-to-N demultiplexer.
package demux_pkg;

  // Upper bound on channel count that the decode helper can express.
  localparam int MAX_OUT = 64;

  // Select width for a given channel count; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One-hot decode of sel over n channels. The result is all zeros when sel
  // does not name a real channel, which doubles as the in-range test.
  function automatic logic [MAX_OUT-1:0] onehot_dec(input int sel, input int n);
    logic [MAX_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if ((i < n) && (sel == i)) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: a valid bit and a data word per output channel.
// valid_o/data_o are the consumer handshake; the word leaves when valid_o and
// ready_i are both high at a rising edge.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             free_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Slot can accept when empty or when it is being drained this very cycle.
  assign free_o = !valid_q | ready_i;

  // Load wins over drain so a drain+refill keeps the slot full; data holds
  // its last value after a plain drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_router_reg.sv
// Registered 1-to-N_OUT demultiplexer with a one-entry slot per channel.
// Handshake: a word moves on a rising edge when valid and ready are both 1
// on that interface; ready never depends on valid, and no path runs
// combinationally from the in_* side to the out_* side.
module demux_router_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   sel_err
);

  logic [MAX_OUT-1:0] dec_full;
  logic               unused_dec_bits;
  logic [N_OUT-1:0]   dec;
  logic [N_OUT-1:0]   free;
  logic [N_OUT-1:0]   load;
  logic               in_range;
  logic               accept;
  logic               sel_err_q, sel_err_d;

  // Destination decode; an all-zero result marks an out-of-range select.
  always_comb begin
    dec_full = onehot_dec(int'(in_sel), N_OUT);
  end

  assign dec             = dec_full[N_OUT-1:0];
  assign unused_dec_bits = ^dec_full;
  assign in_range        = |dec;

  // Ready: broadcast needs every slot, unicast needs its own slot, and an
  // out-of-range word is always swallowed. Held low throughout reset.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (in_bcast)      in_ready = &free;
      else if (in_range) in_ready = |(free & dec);
      else               in_ready = 1'b1;
    end
  end

  assign accept = in_valid & in_ready;

  // Per-slot load enables; broadcast is all-or-nothing through in_ready.
  always_comb begin
    load = '0;
    if (accept) begin
      if (in_bcast) load = '1;
      else          load = dec;
    end
  end

  assign sel_err_d = accept & !in_bcast & !in_range;

  // One-cycle error pulse for an accepted word with no real destination.
  always_ff @(posedge clk) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[k]),
      .data_i (in_data),
      .ready_i(out_ready[k]),
      .valid_o(out_valid[k]),
      .data_o (out_data[k*WIDTH +: WIDTH]),
      .free_o (free[k])
    );
  end

endmodule

// File: tb/tb_demux_router_reg.sv
// Bench for demux_router_reg: a 4-channel instance driven by directed and
// random traffic against a per-channel queue model, plus a 3-channel
// instance used for the out-of-range select case.
module tb_demux_router_reg;

  localparam int W = 8;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 4-channel DUT ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_bcast = 1'b0;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready = '1;
  logic [N*W-1:0] out_data;
  logic         sel_err;

  demux_router_reg #(.WIDTH(W), .N_OUT(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel_err(sel_err)
  );

  // ---------------- 3-channel DUT ----------------
  logic         v3 = 1'b0;
  logic         rdy3;
  logic [W-1:0] d3 = '0;
  logic [1:0]   s3 = '0;
  logic         b3 = 1'b0;
  logic [2:0]   ov3;
  logic [2:0]   or3 = 3'b111;
  logic [3*W-1:0] od3;
  logic         err3;

  demux_router_reg #(.WIDTH(W), .N_OUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(rdy3),
    .in_data(d3), .in_sel(s3), .in_bcast(b3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .sel_err(err3)
  );

  // ---------------- model / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q [N][$];
  logic [N-1:0] occ = '0;
  logic [W-1:0] last_word [N];
  logic         exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_model();
    occ = '0;
    exp_err = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      last_word[k] = '0;
    end
  endtask

  // Monitor: compares occupancy/error against the model and pops the
  // expected word for every channel that hands one off at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("sel_err", 32'(sel_err), 32'(exp_err));
        for (int k = 0; k < N; k++) begin
          chk($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(occ[k]));
          if (out_valid[k] && out_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              chk($sformatf("unexpected_word%0d", k), 32'(out_data[k*W +: W]), 32'hFFFF_FFFF);
            end else begin
              logic [W-1:0] e;
              e = exp_q[k].pop_front();
              chk($sformatf("data%0d", k), 32'(out_data[k*W +: W]), 32'(e));
              last_word[k] = e;
            end
          end else if (!out_valid[k]) begin
            chk($sformatf("idle_data%0d", k), 32'(out_data[k*W +: W]), 32'(last_word[k]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; presents one cycle of stimulus, checks
  // in_ready against the model and advances the model at the next edge.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                       input logic b, input logic [N-1:0] r);
    logic [N-1:0] free;
    logic exp_rdy, acc;
    in_valid = v; in_data = d; in_sel = s; in_bcast = b; out_ready = r;
    free = ~occ | r;
    exp_rdy = b ? (&free) : free[s];
    acc = v & exp_rdy;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    for (int k = 0; k < N; k++) begin
      if (acc && (b || (int'(s) == k))) begin
        occ[k] = 1'b1;
        exp_q[k].push_back(d);
      end else if (r[k]) begin
        occ[k] = 1'b0;
      end
    end
    exp_err = 1'b0;
    #1;
  endtask

  task automatic reset_dut(input int cycles);
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 8'hC3; in_sel = 2'd1; in_bcast = 1'b0; out_ready = '1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      if (i > 0) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
      end
      @(posedge clk);
      clear_model();
    end
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_model();

    // Reset with a pending word, then release.
    reset_dut(3);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Out-of-range select on the 3-channel instance.
    v3 = 1'b1; s3 = 2'd3; d3 = 8'hFF;
    @(negedge clk);
    chk("oor_ready", 32'(rdy3), 32'd1);
    @(posedge clk); #1;
    v3 = 1'b0;
    @(negedge clk);
    chk("oor_sel_err", 32'(err3), 32'd1);
    chk("oor_valid", 32'(ov3), 32'd0);
    @(negedge clk);
    chk("oor_err_pulse", 32'(err3), 32'd0);
    @(posedge clk); #1;
    v3 = 1'b1; s3 = 2'd2; d3 = 8'h42;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(negedge clk);
    chk("n3_valid", 32'(ov3), 32'h4);
    chk("n3_data", 32'(od3[2*W +: W]), 32'h42);
    chk("n3_no_err", 32'(err3), 32'd0);
    @(posedge clk); #1;

    // Unicast sweep, back to back.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hA0 + 8'(i), 2'(i), 1'b0, 4'hF);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Back-pressure on channel 2 while channel 1 keeps flowing.
    drive(1'b1, 8'h11, 2'd2, 1'b0, 4'b1011);
    drive(1'b1, 8'h22, 2'd2, 1'b0, 4'b1011);
    drive(1'b1, 8'h33, 2'd1, 1'b0, 4'b1011);
    drive(1'b1, 8'h22, 2'd2, 1'b0, 4'b1111);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Broadcast blocked by a full channel 3, then released.
    drive(1'b1, 8'h77, 2'd3, 1'b0, 4'b0111);
    drive(1'b1, 8'h5A, 2'd0, 1'b1, 4'b0111);
    drive(1'b1, 8'h5A, 2'd0, 1'b1, 4'b1111);
    chk("bcast_valid", 32'(out_valid), 32'hF);
    for (int k = 0; k < N; k++) chk("bcast_data", 32'(out_data[k*W +: W]), 32'h5A);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Drain and refill channel 0 every cycle.
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i + 1), 2'd0, 1'b0, 4'hF);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) reset_dut(2);
      drive($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
    end

    // Flush and confirm every accepted word was delivered.
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    for (int k = 0; k < N; k++) chk("residual", 32'(exp_q[k].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
